ct_reader: RTL and testbench

//   Reads a length-prefixed ciphertext message out of a 256x8 synchronous-read memory and streams its bytes to the decrypt path.

---
 rtl/ct_reader.sv | 104 ++++++++++
 tb/tb_ct_reader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ct_reader.sv
// Streams a length-prefixed message (ct[0]=L, ct[1..L]=bytes) from a sync-read memory.
// First beat 4 cycles after the start handshake; a 2-entry prefetch FIFO holds its head while out_ready is low.
module ct_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rddata,
  output logic [7:0]        len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        out_idx,
  output logic              out_last
);

  localparam int PW = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, LEN_RD, LEN_CAP, STREAM, DRAIN} state_t;

  state_t            state;
  logic [PW-1:0]     p;
  logic              inflight;
  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              pop;
  logic              issue;

  assign rdy       = (state == IDLE);
  assign out_valid = (count != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];
  assign out_last  = out_valid && (out_idx == len - 8'd1);
  assign pop       = out_valid && out_ready;

  // A same-cycle pop frees a slot, so the fetch can run back-to-back at full rate
  // while the data in flight always lands in a free entry.
  assign issue = (state == STREAM) &&
                 (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

  always_comb begin
    addr = '0;
    case (state)
      STREAM:  addr = p[ADDR_W-1:0];
      DRAIN:   addr = ADDR_W'(len);
      default: addr = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      p           <= '0;
      inflight    <= 1'b0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      len         <= 8'd0;
      out_idx     <= 8'd0;
    end else begin
      if (inflight) begin
        fifo_mem[wr_ptr] <= rddata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        out_idx <= out_idx + 8'd1;
      end
      count    <= count + {1'b0, inflight} - {1'b0, pop};
      inflight <= issue;
      if (issue) p <= p + PW'(1);

      case (state)
        IDLE: begin
          if (en) begin
            state   <= LEN_RD;
            out_idx <= 8'd0;
          end
        end
        LEN_RD: state <= LEN_CAP;
        LEN_CAP: begin
          len   <= 8'(rddata);
          p     <= PW'(1);
          state <= (8'(rddata) == 8'd0) ? IDLE : STREAM;
        end
        STREAM: begin
          if (issue && (p == PW'(len))) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && out_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ct_reader.sv
// Directed bench for ct_reader: behavioural sync-read memory plus a beat scoreboard.
module tb_ct_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       rdy;
  logic [7:0] addr;
  logic [7:0] rddata = 8'd0;
  logic [7:0] len;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic [7:0] out_idx;
  logic       out_last;

  ct_reader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .addr(addr), .rddata(rddata),
    .len(len), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) rddata <= mem[addr];

  typedef struct {
    logic [7:0] d;
    logic [7:0] idx;
    logic       last;
  } beat_t;

  beat_t sb [$];

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc, first_vld, done_at, addr_z_bad, addr_nz_bad;
  logic prev_stall = 1'b0;
  logic [7:0] held;
  logic rdy_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check at negedge, return 1 time unit after the posedge.
  task automatic tick();
    beat_t e;
    @(negedge clk);
    rdy_s = rdy;
    if (out_valid && first_vld < 0) first_vld = cyc;
    if (rdy && cyc > 0 && done_at < 0) done_at = cyc;
    if (prev_stall) chk("head_stable", out_data, held);
    prev_stall = out_valid && !out_ready;
    held = out_data;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", out_data, 32'hffff_ffff);
      end else begin
        e = sb.pop_front();
        chk("beat_data", out_data, e.d);
        chk("beat_idx", out_idx, e.idx);
        chk("beat_last", out_last, e.last);
      end
    end
    if (!rdy && cyc >= 3 && addr == 8'd0) addr_z_bad++;
    if (addr != 8'd0) addr_nz_bad++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push_exp(input int l);
    for (int i = 1; i <= l; i++) sb.push_back('{d: mem[i], idx: 8'(i - 1), last: (i == l)});
  endtask

  task automatic run(input int l, input int stall_lo, input int stall_hi,
                     input int exp_first, input int exp_done);
    mem[0] = 8'(l);
    push_exp(l);
    cyc = 0; first_vld = -1; done_at = -1; addr_z_bad = 0; addr_nz_bad = 0;
    chk("idle_rdy", rdy, 1);
    en = 1'b1;
    out_ready = 1'b1;
    tick();
    en = 1'b0;
    while (done_at < 0 && cyc < 600) begin
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      tick();
    end
    out_ready = 1'b1;
    chk("done_in_budget", done_at >= 0, 1);
    if (exp_first >= 0) chk("first_valid_cycle", first_vld, exp_first);
    if (exp_done >= 0) chk("rdy_return_cycle", done_at, exp_done);
    chk("scoreboard_empty", sb.size(), 0);
    chk("len_latched", len, l);
    chk("addr_no_wrap", addr_z_bad, 0);
    if (l == 0) begin
      chk("l0_no_valid", first_vld, 32'hffff_ffff);
      chk("l0_addr_only_0", addr_nz_bad, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"}, rdy, 1);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_len"}, len, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_idx"}, out_idx, 0);
    chk({tag, "_last"}, out_last, 0);
  endtask

  logic [11:0] rdy_pat;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // L=0: only the length read, back to idle two edges after the handshake.
    run(0, -1, -1, -1, 3);

    mem[1] = 8'hAA; mem[2] = 8'hBB; mem[3] = 8'hCC;
    run(3, -1, -1, 5, 8);

    for (int i = 1; i <= 5; i++) mem[i] = 8'(8'h40 + i);
    run(5, 6, 10, 5, -1);

    for (int i = 1; i < 256; i++) mem[i] = 8'(i);
    run(255, -1, -1, 5, 260);

    // en held high: a second run only begins once rdy has returned.
    mem[0] = 8'd1; mem[1] = 8'h5A;
    push_exp(1); push_exp(1);
    cyc = 0; first_vld = -1; done_at = -1;
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      rdy_pat[i] = rdy_s;
    end
    en = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("en_held_rdy_pattern", rdy_pat, 12'h041);
    chk("en_held_sb_empty", sb.size(), 0);

    // Reset mid-stream of L=10, then a clean L=2 run.
    for (int i = 1; i <= 10; i++) mem[i] = 8'(8'h90 + i);
    mem[0] = 8'd10;
    push_exp(10);
    cyc = 0; first_vld = -1; done_at = -1;
    en = 1'b1;
    tick();
    en = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("pre_reset_streaming", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mem[1] = 8'h12; mem[2] = 8'h34;
    run(2, -1, -1, 5, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
